// File: rtl/mcp23s17_spi_master.sv
// SPI mode 0 master that turns one register read/write request into a 3-byte
// MCP23S17 frame (opcode, register, data) and returns read data with a strobe.
module mcp23s17_spi_master #(
  parameter int         CLK_DIV = 25,
  parameter logic [2:0] HW_ADDR = 3'b000
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RW,
  input  logic [7:0] REQ_REG,
  input  logic [7:0] REQ_WDATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_RDATA,
  output logic       BUSY,
  output logic       JS_CS,
  output logic       JS_SCK,
  output logic       JS_MOSI,
  input  logic       JS_MISO,
  output logic [2:0] DBG_STATE
);

  // Request handshake: a request is taken on the rising edge where
  // REQ_VALID and REQ_READY are both high; REQ_READY is high only in IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] tx_sr;
  logic [7:0]  rx_sr;
  logic        rd_op;
  logic        miso_s1;
  logic        miso_s2;
  logic [23:0] frame_in;

  assign frame_in  = {4'b0100, HW_ADDR, REQ_RW, REQ_REG, (REQ_RW ? 8'h00 : REQ_WDATA)};
  assign BUSY      = ~REQ_READY;
  assign DBG_STATE = state;

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= JS_MISO;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 8'h00;
      JS_CS     <= 1'b1;
      JS_SCK    <= 1'b0;
      JS_MOSI   <= 1'b0;
      div_cnt   <= 8'd0;
      bit_cnt   <= 5'd0;
      tx_sr     <= 24'd0;
      rx_sr     <= 8'd0;
      rd_op     <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            tx_sr     <= frame_in;
            rd_op     <= REQ_RW;
            JS_MOSI   <= frame_in[23];
            JS_CS     <= 1'b0;
            REQ_READY <= 1'b0;
            div_cnt   <= DIV_RELOAD;
            bit_cnt   <= 5'd0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_cnt == 8'd0) begin
            div_cnt <= DIV_RELOAD;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_RELOAD;
            if (!JS_SCK) begin
              JS_SCK <= 1'b1;
            end else begin
              // Last cycle of the high phase: sample MISO, then drop SCK.
              JS_SCK <= 1'b0;
              rx_sr  <= {rx_sr[6:0], miso_s2};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= 5'd0;
                state   <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
                tx_sr   <= {tx_sr[22:0], 1'b0};
                JS_MOSI <= tx_sr[22];
              end
            end
          end
        end
        ST_HOLD: begin
          if (div_cnt == 8'd0) begin
            div_cnt   <= DIV_RELOAD;
            JS_CS     <= 1'b1;
            RSP_VALID <= 1'b1;
            if (rd_op) RSP_RDATA <= rx_sr;
            state     <= ST_GAP;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          if (div_cnt == 8'd0) begin
            div_cnt   <= 8'd0;
            JS_MOSI   <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          REQ_READY <= 1'b1;
          JS_CS     <= 1'b1;
          JS_SCK    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mcp23s17_spi_master.md
Name: mcp23s17_spi_master

Overview:
- Byte-frame SPI master for the MCP23S17 GPIO expander on the LTC connector (SPIM1 loan-IO pins).
- Sits directly downstream of the joystick/GPIO polling controller. Converts one register read or write request into a 3-byte MCP23S17 frame on JS_CS/JS_SCK/JS_MOSI/JS_MISO.
- Returns read data with a one-cycle response strobe.
- SPI mode 0, MSB first, one transaction in flight.

Parameters:
- CLK_DIV, 25, CLK_50 cycles per SCK half-period. Legal range 2..255; default gives 1 MHz SCK.
- HW_ADDR, 3'b000, MCP23S17 hardware address (A2..A0) inserted in the opcode.

Ports:
- CLK_50 input 1: system clock; all logic on its rising edge.
- RESET_N input 1: synchronous, active-low reset.
- REQ_VALID input 1: request present.
- REQ_READY output 1: block can accept a request.
- REQ_RW input 1: 1 = read, 0 = write.
- REQ_REG input 8: MCP23S17 register address.
- REQ_WDATA input 8: write data; ignored for reads.
- RSP_VALID output 1: one-cycle strobe at transaction end.
- RSP_RDATA output 8: read data; valid when RSP_VALID follows a read.
- BUSY output 1: high from accept until return to IDLE.
- JS_CS output 1: chip select, active low.
- JS_SCK output 1: SPI clock, idle low.
- JS_MOSI output 1: SPI data out.
- JS_MISO input 1: SPI data in; asynchronous, synchronised internally.

Behaviour:
- Clock and reset: one clock, CLK_50. RESET_N is synchronous, active-low.
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_RDATA=8'h00, BUSY=0, JS_CS=1, JS_SCK=0, JS_MOSI=0. The state machine goes to IDLE and all counters clear.
- Reset mid-frame: on the next edge JS_CS=1 and JS_SCK=0. The frame is abandoned and no RSP_VALID is issued.
- Accept: the handshake completes on an edge where REQ_VALID=1 and REQ_READY=1.
  - REQ_READY is high only in IDLE.
  - REQ_RW, REQ_REG and REQ_WDATA are latched on the accept edge and are don't-care afterwards.
- Frame contents, 24 bits:
  - Byte 1 (opcode): {4'b0100, HW_ADDR, REQ_RW}.
  - Byte 2: REQ_REG.
  - Byte 3: REQ_WDATA for a write; 8'h00 for a read.
- State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: JS_CS=1, JS_SCK=0, REQ_READY=1. Accepting a request moves to SETUP.
- SETUP: lasts CLK_DIV cycles, starting the cycle after accept. JS_CS=0, JS_MOSI=frame bit 23, JS_SCK=0.
- SHIFT: 24 bits, each a low phase of CLK_DIV cycles then a high phase of CLK_DIV cycles.
  - JS_MOSI changes only on the edge where JS_SCK goes 1 to 0, to the next bit.
  - JS_MISO passes through a 2-flop synchroniser. It is sampled into the shift register on the last CLK_50 cycle of each high phase.
  - Exactly 24 SCK rising edges occur per frame.
- HOLD: CLK_DIV cycles with JS_CS=0 and JS_SCK=0.
- GAP: CLK_DIV cycles with JS_CS=1.
  - RSP_VALID=1 only on the first GAP cycle, the same cycle JS_CS returns high.
  - For reads, RSP_RDATA = the last 8 sampled bits, MSB first, updated on that cycle. For writes, RSP_RDATA holds its previous value.
- Timing summary:
  - JS_CS is low for exactly 50*CLK_DIV cycles.
  - Accept-to-RSP_VALID latency is 50*CLK_DIV+1 cycles.
  - Minimum JS_CS-high time between back-to-back frames is CLK_DIV+1 cycles (GAP plus the accept cycle).
- BUSY = NOT REQ_READY.
- A REQ_VALID asserted while busy is not accepted and is not lost; it is taken on the first IDLE cycle.
- The SCK divider counter and the bit counter are 8-bit and 5-bit. Both reload or clear at every phase and state change and never wrap mid-phase.

Test Plan:
- Write, CLK_DIV=2, HW_ADDR=0, REQ_RW=0, REQ_REG=8'h00, REQ_WDATA=8'hFF -> MOSI bytes 40 00 FF, 24 SCK rises, JS_CS low 100 cycles, RSP_VALID at accept+101, RSP_RDATA unchanged (8'h00).
- Read, CLK_DIV=2, REQ_RW=1, REQ_REG=8'h13, MISO model drives 8'hA5 during byte 3 -> MOSI bytes 41 13 00, RSP_VALID one cycle, RSP_RDATA=8'hA5.
- HW_ADDR=3'b101, one read and one write -> opcode bytes 8'h4B and 8'h4A respectively.
- REQ_VALID held high across two requests (write 8'h12<-8'h3C then read 8'h12) -> REQ_READY low throughout frame 1, JS_CS high for exactly CLK_DIV+1=3 cycles between frames, second frame correct, exactly two RSP_VALID pulses.
- RESET_N low for 1 cycle at SHIFT bit 10 -> next cycle JS_CS=1, JS_SCK=0, REQ_READY=1, BUSY=0, no RSP_VALID; a subsequent read returns correct data.
- CLK_DIV=25 default read -> SCK period 50 cycles, high and low phases 25 cycles each, JS_CS low 1250 cycles.
